// File: rtl/storage_arbiter_pkg.sv
// Shared definitions for the matrix-storage arbiter: port ids, FSM encoding,
// default widths and one-hot/id conversion helpers.
package storage_arbiter_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef logic [1:0] port_id_t;

  localparam port_id_t PORT_IN   = 2'd0;
  localparam port_id_t PORT_DISP = 2'd1;
  localparam port_id_t PORT_CALC = 2'd2;
  localparam port_id_t PORT_NONE = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  function automatic port_id_t oh_to_id(input logic [2:0] oh);
    if (oh[0]) return PORT_IN;
    if (oh[1]) return PORT_DISP;
    if (oh[2]) return PORT_CALC;
    return PORT_NONE;
  endfunction

  function automatic logic [2:0] id_to_oh(input port_id_t id);
    case (id)
      PORT_IN:   return 3'b001;
      PORT_DISP: return 3'b010;
      PORT_CALC: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/storage_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: first requester after the last
// winner, wrapping modulo 3. Any last value outside 0..2 gives port 0 priority.
module rr_pick3
  import storage_arbiter_pkg::*;
(
  input  logic [2:0] req_i,
  input  port_id_t   last_i,
  output logic [2:0] win_o
);

  always_comb begin
    win_o = 3'b000;
    case (last_i)
      PORT_IN: begin
        if (req_i[1])      win_o = 3'b010;
        else if (req_i[2]) win_o = 3'b100;
        else if (req_i[0]) win_o = 3'b001;
      end
      PORT_DISP: begin
        if (req_i[2])      win_o = 3'b100;
        else if (req_i[0]) win_o = 3'b001;
        else if (req_i[1]) win_o = 3'b010;
      end
      default: begin
        if (req_i[0])      win_o = 3'b001;
        else if (req_i[1]) win_o = 3'b010;
        else if (req_i[2]) win_o = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/storage_arbiter.sv
// Request/grant arbiter sharing the single-port storage RAM between the input
// writer, display reader and calculator, with burst locking and a lock watchdog.
module storage_arbiter
  import storage_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_LOCK = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [2:0]          lock,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          owner,
  output logic                lock_err,
  input  logic                clr_err,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;

  logic [0:0]       st_q, st_d;
  port_id_t         owner_q, owner_d;
  port_id_t         last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [2:0]       rvalid_q, rvalid_d;
  logic [2:0]       rr_win;
  logic [2:0]       gnt_c;
  logic [2:0]       gnt_s;
  logic [2:0]       owner_oh;
  logic             wd_fire;

  rr_pick3 u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (rr_win)
  );

  assign owner_oh = id_to_oh(owner_q);

  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_c   = 3'b000;
    wd_fire = 1'b0;
    if (st_q == ST_IDLE) begin
      gnt_c = rr_win;
      if (|rr_win) begin
        last_d = oh_to_id(rr_win);
        if (|(rr_win & lock)) begin
          st_d    = ST_OWNED;
          owner_d = oh_to_id(rr_win);
          cnt_d   = CNT_W'(1);
        end
      end
    end else begin
      gnt_c = owner_oh & req;
      // A lock without a matching request counts as released.
      if (!(|(owner_oh & lock & req))) begin
        st_d    = ST_IDLE;
        owner_d = PORT_NONE;
        cnt_d   = '0;
      end else if (cnt_q == CNT_W'(MAX_LOCK - 1)) begin
        st_d    = ST_IDLE;
        owner_d = PORT_NONE;
        cnt_d   = '0;
        last_d  = owner_q;
        wd_fire = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign gnt_s    = rst ? 3'b000 : gnt_c;
  assign rvalid_d = gnt_s & ~we;
  assign err_d    = wd_fire ? 1'b1 : (clr_err ? 1'b0 : err_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      owner_q  <= PORT_NONE;
      last_q   <= PORT_CALC;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 3'b000;
    end else begin
      st_q     <= st_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_s[i]) begin
        mem_we    = we[i];
        mem_addr  = addr[i*ADDR_W +: ADDR_W];
        mem_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign gnt      = gnt_s;
  assign rvalid   = rst ? 3'b000 : rvalid_q;
  assign rdata    = mem_rdata;
  assign owner    = owner_q;
  assign lock_err = err_q;

endmodule

// File: tb/tb_storage_arbiter.sv
// Scoreboard bench for storage_arbiter: directed per-cycle vectors push expected
// grant/owner/error/memory/rvalid values; a negedge monitor pops and compares.
module tb_storage_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int ML = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req, lock, we;
  logic [AW-1:0] a [3];
  logic [DW-1:0] d [3];
  logic [3*AW-1:0] addr_bus;
  logic [3*DW-1:0] wdata_bus;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    owner;
  logic          lock_err, clr_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] ram [0:(1<<AW)-1];

  assign addr_bus  = {a[2], a[1], a[0]};
  assign wdata_bus = {d[2], d[1], d[0]};

  storage_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .addr(addr_bus), .wdata(wdata_bus), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .owner(owner), .lock_err(lock_err), .clr_err(clr_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic [2:0]    gnt;
    logic [1:0]    owner;
    logic          err;
    bit            cm;
    logic          mwe;
    logic [AW-1:0] maddr;
    bit            crv;
    logic [2:0]    rv;
  } exp_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } rd_t;

  exp_t expq[$];
  rd_t  rdq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  exp_t e_mon;
  rd_t  r_mon;
  always @(negedge clk) begin
    if (expq.size() != 0) begin
      e_mon = expq.pop_front();
      check("gnt", {29'd0, gnt}, {29'd0, e_mon.gnt});
      check("owner", {30'd0, owner}, {30'd0, e_mon.owner});
      check("lock_err", {31'd0, lock_err}, {31'd0, e_mon.err});
      if (e_mon.cm) begin
        check("mem_we", {31'd0, mem_we}, {31'd0, e_mon.mwe});
        check("mem_addr", {23'd0, mem_addr}, {23'd0, e_mon.maddr});
      end
      if (e_mon.crv) check("rvalid", {29'd0, rvalid}, {29'd0, e_mon.rv});
    end
    if (rvalid != 3'b000) begin
      if (rdq.size() == 0) begin
        check("unexpected_rvalid", {29'd0, rvalid}, 32'd0);
      end else begin
        r_mon = rdq.pop_front();
        check("rvalid_port", {29'd0, rvalid}, 32'd1 << r_mon.port);
        check("rdata", rdata, r_mon.data);
      end
    end
  end

  task automatic tick(input logic [2:0] g, input logic [1:0] o, input logic e,
                      input bit cm, input logic mw, input logic [AW-1:0] ma,
                      input bit crv, input logic [2:0] rv);
    exp_t x;
    x.gnt = g; x.owner = o; x.err = e; x.cm = cm; x.mwe = mw; x.maddr = ma;
    x.crv = crv; x.rv = rv;
    expq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
    req = r; lock = l; we = w;
  endtask

  initial begin
    rst = 1'b1; clr_err = 1'b0;
    drive(3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) begin a[i] = '0; d[i] = '0; end
    @(posedge clk); #1;
    tick(3'b000, 2'd3, 1'b0, 1, 1'b0, 9'd0, 1, 3'b000);
    rst = 1'b0;

    // Idle: we/addr present without req are ignored.
    a[0] = 9'd7; a[1] = 9'd8; a[2] = 9'd9;
    drive(3'b000, 3'b000, 3'b111);
    for (int i = 0; i < 3; i++) tick(3'b000, 2'd3, 1'b0, 1, 1'b0, 9'd0, 1, 3'b000);

    // Round robin with all ports requesting writes.
    a[0] = 9'd100; a[1] = 9'd101; a[2] = 9'd102;
    drive(3'b111, 3'b000, 3'b111);
    for (int i = 0; i < 6; i++)
      tick(3'b001 << (i % 3), 2'd3, 1'b0, 1, 1'b1, 9'd100 + 9'(i % 3), 1, 3'b000);

    // Port 2 locked write burst to 10..13 while ports 0 and 1 keep requesting.
    a[0] = 9'd200; a[1] = 9'd201; a[2] = 9'd10; d[2] = 32'h1000_000A;
    drive(3'b111, 3'b100, 3'b111);
    tick(3'b001, 2'd3, 1'b0, 1, 1'b1, 9'd200, 1, 3'b000);
    tick(3'b010, 2'd3, 1'b0, 1, 1'b1, 9'd201, 1, 3'b000);
    tick(3'b100, 2'd3, 1'b0, 1, 1'b1, 9'd10, 1, 3'b000);
    a[2] = 9'd11; d[2] = 32'h1000_000B;
    tick(3'b100, 2'd2, 1'b0, 1, 1'b1, 9'd11, 1, 3'b000);
    a[2] = 9'd12; d[2] = 32'h1000_000C;
    tick(3'b100, 2'd2, 1'b0, 1, 1'b1, 9'd12, 1, 3'b000);
    a[2] = 9'd13; d[2] = 32'h1000_000D;
    drive(3'b111, 3'b000, 3'b111);
    tick(3'b100, 2'd2, 1'b0, 1, 1'b1, 9'd13, 1, 3'b000);
    tick(3'b001, 2'd3, 1'b0, 1, 1'b1, 9'd200, 1, 3'b000);

    // Write then read-back of the same address on the next cycle.
    a[0] = 9'd5; d[0] = 32'hDEAD_BEEF;
    drive(3'b001, 3'b000, 3'b001);
    tick(3'b001, 2'd3, 1'b0, 1, 1'b1, 9'd5, 1, 3'b000);
    a[1] = 9'd5;
    drive(3'b010, 3'b000, 3'b000);
    rdq.push_back('{port: 1, data: 32'hDEAD_BEEF});
    tick(3'b010, 2'd3, 1'b0, 1, 1'b0, 9'd5, 1, 3'b000);
    drive(3'b000, 3'b000, 3'b000);
    tick(3'b000, 2'd3, 1'b0, 1, 1'b0, 9'd0, 1, 3'b010);

    // Watchdog: port 0 holds its lock, port 1 waits.
    a[0] = 9'd300; a[1] = 9'd301;
    drive(3'b011, 3'b001, 3'b011);
    tick(3'b001, 2'd3, 1'b0, 1, 1'b1, 9'd300, 1, 3'b000);
    for (int i = 0; i < ML - 1; i++) tick(3'b001, 2'd0, 1'b0, 1, 1'b1, 9'd300, 1, 3'b000);
    tick(3'b010, 2'd3, 1'b1, 1, 1'b1, 9'd301, 1, 3'b000);
    drive(3'b000, 3'b000, 3'b000);
    clr_err = 1'b1;
    tick(3'b000, 2'd3, 1'b1, 1, 1'b0, 9'd0, 1, 3'b000);
    clr_err = 1'b0;
    tick(3'b000, 2'd3, 1'b0, 1, 1'b0, 9'd0, 1, 3'b000);

    // Reset in the middle of a port 2 locked read burst.
    a[2] = 9'd10;
    drive(3'b100, 3'b100, 3'b000);
    rdq.push_back('{port: 2, data: 32'h1000_000A});
    tick(3'b100, 2'd3, 1'b0, 1, 1'b0, 9'd10, 0, 3'b000);
    a[2] = 9'd11;
    tick(3'b100, 2'd2, 1'b0, 1, 1'b0, 9'd11, 1, 3'b100);
    a[2] = 9'd12;
    rst = 1'b1;
    tick(3'b000, 2'd2, 1'b0, 1, 1'b0, 9'd0, 1, 3'b000);
    rst = 1'b0;
    a[0] = 9'd400; a[1] = 9'd401; a[2] = 9'd402;
    drive(3'b111, 3'b000, 3'b111);
    tick(3'b001, 2'd3, 1'b0, 1, 1'b1, 9'd400, 1, 3'b000);
    drive(3'b000, 3'b000, 3'b000);
    tick(3'b000, 2'd3, 1'b0, 1, 1'b0, 9'd0, 1, 3'b000);

    repeat (2) @(posedge clk);
    #1;
    check("expq_drained", expq.size(), 32'd0);
    check("rdq_drained", rdq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
